// File: rtl/alu_result_display_if.sv
// rtl/alu_result_display_if.sv - ALU result inputs and seven-segment display outputs bundle
interface alu_result_display_if;
  logic       res_valid;
  logic [3:0] res;
  logic       overflow;
  logic       carry;
  logic       signed_mode;
  logic [3:0] an;
  logic [7:0] seg;

  // ALU / stimulus side: drives the result, observes the display pins
  modport master (
    output res_valid, res, overflow, carry, signed_mode,
    input  an, seg
  );

  // Display block side: consumes the result, drives the display pins
  modport slave (
    input  res_valid, res, overflow, carry, signed_mode,
    output an, seg
  );
endinterface

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - 4-bit ALU result decoder and 4-digit multiplexed seven-segment driver; optional OVF_BLINK_EN blinks the display while overflow is held
module alu_result_display #(
  parameter int SCAN_DIV = 1000
`ifdef OVF_BLINK_EN
  , parameter int BLINK_DIV = 4
`endif
) (
  input logic                 clk,
  input logic                 rst,
  alu_result_display_if.slave bus
);

  localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_O     = 8'hA3;
  localparam logic [7:0] GLYPH_C     = 8'hA7;

  // Active-low {dp,g,f,e,d,c,b,a} pattern for a decimal digit; dp stays off
  function automatic logic [7:0] digit_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Held result
  logic [3:0] res_q;
  logic       ovf_q;
  logic       carry_q;
  logic       smode_q;
  logic       have_q;

  // Decoded digit glyphs, index 0 is the rightmost digit
  logic [3:0][7:0] dig_d;
  logic [3:0][7:0] dig_q;

  logic       sign_w;
  logic [3:0] mag_w;
  logic       tens_w;
  logic [3:0] ones_w;

  // Scan engine
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [7:0]    seg_q;
  logic          blank_w;

  // Capture the ALU result on the strobe; the latest strobe always wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= 4'd0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      smode_q <= 1'b0;
      have_q  <= 1'b0;
    end else if (bus.res_valid) begin
      res_q   <= bus.res;
      ovf_q   <= bus.overflow;
      carry_q <= bus.carry;
      smode_q <= bus.signed_mode;
      have_q  <= 1'b1;
    end
  end

  // Split the held result into sign, tens and ones, then map each digit to a glyph
  always_comb begin
    sign_w = smode_q & res_q[3];
    mag_w  = sign_w ? (~res_q + 4'd1) : res_q;
    tens_w = (mag_w >= 4'd10);
    ones_w = tens_w ? (mag_w - 4'd10) : mag_w;
    dig_d  = {4{GLYPH_BLANK}};
    if (have_q) begin
      dig_d[0] = digit_glyph(ones_w);
      dig_d[1] = tens_w ? digit_glyph(4'd1) : GLYPH_BLANK;
      dig_d[2] = sign_w ? GLYPH_DASH : GLYPH_BLANK;
      if (ovf_q) begin
        dig_d[3] = GLYPH_O;
      end else if (carry_q) begin
        dig_d[3] = GLYPH_C;
      end else begin
        dig_d[3] = GLYPH_BLANK;
      end
    end
  end

  // Register the decoded glyphs one cycle behind the capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_q <= {4{GLYPH_BLANK}};
    end else begin
      dig_q <= dig_d;
    end
  end

  // Dwell counter and digit index; the index steps once per SCAN_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef OVF_BLINK_EN
  localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic          round_done_w;

  assign round_done_w = (cnt_q == CNT_LAST) && (idx_q == 2'd3);

  // Count full scan rounds and flip the blink phase every BLINK_DIV rounds;
  // a non-overflow capture restarts with the display visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      if (round_done_w) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
      if (bus.res_valid && !bus.overflow) begin
        blink_phase_q <= 1'b0;
      end
    end
  end

  assign blank_w = ovf_q & blink_phase_q;
`else
  assign blank_w = 1'b0;
`endif

  // Drive anode and segments from the same index in the same cycle so they never skew
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= 4'b1111;
      seg_q <= GLYPH_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= blank_w ? GLYPH_BLANK : dig_q[idx_q];
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Consumes the 4-bit add/sub unit's result (sum, overflow, carry) and renders it on a 4-digit multiplexed seven-segment display.
- Decodes the two's-complement or unsigned result into sign and decimal digits, then time-multiplexes the digits.
- Sits between the ALU outputs and the board display pins.
- Captures only on a valid strobe; holds the last result between strobes.

Parameters:
- SCAN_DIV, 1000, clk cycles each digit is driven; legal values ≥2.
- BLINK_DIV, 4, full scan rounds per blink half-period; used only when OVF_BLINK_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- res_valid  in  1  capture strobe for res/overflow/carry; one cycle
- res  in  4  ALU sum
- overflow  in  1  ALU signed-overflow flag
- carry  in  1  ALU carry-out (cout[3])
- signed_mode  in  1  1: res is two's complement; 0: res is unsigned; sampled with res_valid
- an  out  4  digit enables, active-low, one-hot-low
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst=0, async) clears all state:
  - an=4'b1111, seg=8'hFF.
  - held result=0, have_result=0.
  - scan counter=0, digit index=0.
  - Reset mid-operation blanks the display immediately.
- Capture stage: on a clk edge with res_valid=1, register res, overflow, carry, signed_mode and set have_result=1.
  - With res_valid=0 the held values are unchanged.
  - Back-to-back strobes are accepted every cycle; the last one wins.
- Decode stage (registered, 1 cycle after capture):
  - Signed mode: sign=res[3]; mag = sign ? (~res+1) as unsigned 4-bit : res. 4'b1000 gives mag=8, sign=1.
  - Unsigned mode: sign=0, mag=res (0..15).
  - tens = (mag≥10); ones = mag−10*tens.
  - Digit contents:
    - d0 = ones.
    - d1 = '1' if tens, else blank (leading-zero blanking).
    - d2 = '-' if sign, else blank.
    - d3 = 'o' if overflow, 'c' if carry and not overflow, else blank.
  - While have_result=0, all four digits are blank.
- Latency: res_valid sampled at edge N → digit registers updated at edge N+1 → seg shows the new glyph the next time that digit is scanned (at earliest edge N+2).
- Scan engine:
  - Counter runs 0..SCAN_DIV−1 continuously.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - an and seg are registered from the digit index and digit contents in the same cycle, so they always change together.
  - an = ~(4'b0001 << index).
  - Capture and a scan advance in the same cycle are independent; both take effect.
- Glyph codes:
  - Digits 0..9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Specials: '-'=BF, 'o'=A3, 'c'=A7, blank=FF.
  - dp is always 1 (off).

Optional Feature:
- OVF_BLINK_EN defined:
  - A blink counter counts completed scan rounds (index wrap 3→0).
  - Every BLINK_DIV rounds it toggles blink_phase.
  - When the held overflow=1 and blink_phase=1, seg=8'hFF for all digits; an keeps scanning.
  - A capture with overflow=0 forces blink_phase=0.
  - Reset clears blink_phase and the blink counter.
- OVF_BLINK_EN undefined: no blink logic; the overflow display is steady.

Test Plan:
- Reset, then run 4*SCAN_DIV cycles (SCAN_DIV=4) with no strobe → an cycles 1110,1101,1011,0111; seg=FF throughout.
- Strobe res=4'b0111, signed_mode=1, overflow=0, carry=0 → d0=F8 ('7'); d1, d2, d3 all FF.
- Strobe res=4'b1000, signed_mode=1, overflow=1 → d0=80 ('8'), d2=BF ('-'), d3=A3 ('o'). With OVF_BLINK_EN defined, seg=FF on alternate BLINK_DIV rounds.
- Strobe res=4'b1111, signed_mode=0, carry=1 → d0=92 ('5'), d1=F9 ('1'), d3=A7 ('c').
- Strobe on the same edge the scan index wraps, followed by a second strobe next cycle → display shows only the second result from the next digit-0 scan on.
- Assert rst low mid-scan, asynchronous to clk → an=1111 and seg=FF immediately; after release, the display stays blank until the next res_valid.
